cache_valid_array: RTL and testbench

Valid-bit storage and write-side decoder for the 4-way set-associative cache. It takes a set index and way number and decodes them to a single valid bit to set or clear, which is the write direction of the per-set valid selection. It also runs a sequenced flush that invalidates one set per cycle, and provides a registered read port returning all way-valid bits of one set. It sits between the cache controller (writes, flush requests) and the hit-detection logic (reads).

---
 rtl/cache_valid_array.sv | 165 ++++++++++++++++
 tb/tb_cache_valid_array.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_valid_array.sv
// Valid-bit storage for a set-associative cache: decoded single-bit writes,
// a one-set-per-cycle flush walk, and a registered per-set read port.
module cache_valid_array #(
  parameter int NUM_SETS = 8,
  parameter int NUM_WAYS = 4,
  parameter int IDX_W    = 3,
  parameter int WAY_W    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [IDX_W-1:0]    wr_set,
  input  logic [WAY_W-1:0]    wr_way,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic                flush_req,
  output logic                flush_busy,
  output logic                flush_done,
  input  logic                rd_en,
  input  logic [IDX_W-1:0]    rd_set,
  output logic [NUM_WAYS-1:0] rd_valid_ways,
  output logic                rd_vld
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FLUSH = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                             r_state;
  state_t                             w_next_state;
  logic [IDX_W-1:0]                   r_cnt;
  logic [IDX_W-1:0]                   w_cnt_next;
  logic                               w_wr_accept;
  logic                               w_clear;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]  r_valid;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]  w_wr_sel;
  logic [NUM_SETS-1:0]                w_clr_sel;
  logic [NUM_WAYS-1:0]                r_rd_ways;
  logic                               r_rd_vld;
  logic                               r_wr_ready;
  logic                               r_flush_busy;
  logic                               r_flush_done;

  // Flush sequencer state and set counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next_state;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state logic; writes are only accepted outside the flush walk
  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_wr_accept  = 1'b0;
    w_clear      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_wr_accept = wr_en;
        if (flush_req) begin
          w_next_state = S_FLUSH;
          w_cnt_next   = '0;
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_FLUSH: begin
        w_clear    = 1'b1;
        w_cnt_next = r_cnt + IDX_W'(1);
        if (r_cnt == IDX_W'(NUM_SETS - 1)) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_FLUSH;
        end
      end
      S_DONE: begin
        w_wr_accept  = wr_en;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Decode set/way into one-hot write enables and the flushed set
  always_comb begin
    w_wr_sel  = '0;
    w_clr_sel = '0;
    for (int s = 0; s < NUM_SETS; s++) begin
      if (w_clear && (r_cnt == IDX_W'(s))) begin
        w_clr_sel[s] = 1'b1;
      end else begin
        w_clr_sel[s] = 1'b0;
      end
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (w_wr_accept && (wr_set == IDX_W'(s)) && (wr_way == WAY_W'(w))) begin
          w_wr_sel[s][w] = 1'b1;
        end else begin
          w_wr_sel[s][w] = 1'b0;
        end
      end
    end
  end

  // Valid-bit array; a flush clear of a set takes precedence over a write
  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid <= '0;
    end else begin
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (w_clr_sel[s]) begin
            r_valid[s][w] <= 1'b0;
          end else if (w_wr_sel[s][w]) begin
            r_valid[s][w] <= wr_valid;
          end else begin
            r_valid[s][w] <= r_valid[s][w];
          end
        end
      end
    end
  end

  // Read port samples the array before any same-edge update
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ways <= '0;
      r_rd_vld  <= 1'b0;
    end else if (rd_en) begin
      r_rd_ways <= r_valid[rd_set];
      r_rd_vld  <= 1'b1;
    end else begin
      r_rd_ways <= r_rd_ways;
      r_rd_vld  <= 1'b0;
    end
  end

  // Status flags registered from the next state so they track r_state exactly
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ready   <= 1'b1;
      r_flush_busy <= 1'b0;
      r_flush_done <= 1'b0;
    end else begin
      r_wr_ready   <= (w_next_state != S_FLUSH);
      r_flush_busy <= (w_next_state == S_FLUSH);
      r_flush_done <= (w_next_state == S_DONE);
    end
  end

  assign wr_ready      = r_wr_ready;
  assign flush_busy    = r_flush_busy;
  assign flush_done    = r_flush_done;
  assign rd_valid_ways = r_rd_ways;
  assign rd_vld        = r_rd_vld;

endmodule

// File: tb/tb_cache_valid_array.sv
// Self-checking bench for cache_valid_array: directed scenarios plus random
// traffic compared against a behavioural model of the valid array and flush walk.
module tb_cache_valid_array;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [2:0] wr_set;
  logic [1:0] wr_way;
  logic       wr_valid;
  logic       wr_ready;
  logic       flush_req;
  logic       flush_busy;
  logic       flush_done;
  logic       rd_en;
  logic [2:0] rd_set;
  logic [3:0] rd_valid_ways;
  logic       rd_vld;

  int vectors = 0;
  int miscompares = 0;

  // Model: memory contents, flush phase (-1 idle, 0..7 clearing set k, 8 done)
  bit         m_mem [0:7][0:3];
  int         m_phase = -1;
  logic [3:0] m_rd = 4'b0000;
  logic       m_vld = 1'b0;

  cache_valid_array #(.NUM_SETS(8), .NUM_WAYS(4), .IDX_W(3), .WAY_W(2)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_set(wr_set), .wr_way(wr_way), .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .flush_req(flush_req), .flush_busy(flush_busy), .flush_done(flush_done),
    .rd_en(rd_en), .rd_set(rd_set), .rd_valid_ways(rd_valid_ways), .rd_vld(rd_vld)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    reset = 1'b0; wr_en = 1'b0; wr_set = 3'd0; wr_way = 2'd0; wr_valid = 1'b0;
    flush_req = 1'b0; rd_en = 1'b0; rd_set = 3'd0;
  endtask

  // Apply current inputs at one rising edge and advance the model
  task automatic tick();
    logic [3:0] pre;
    @(posedge clk);
    if (reset) begin
      for (int s = 0; s < 8; s++) for (int w = 0; w < 4; w++) m_mem[s][w] = 1'b0;
      m_phase = -1; m_rd = 4'b0000; m_vld = 1'b0;
    end else begin
      for (int w = 0; w < 4; w++) pre[w] = m_mem[rd_set][w];
      if (wr_en && (m_phase < 0 || m_phase == 8)) m_mem[wr_set][wr_way] = wr_valid;
      if (m_phase >= 0 && m_phase < 8) for (int w = 0; w < 4; w++) m_mem[m_phase][w] = 1'b0;
      if (rd_en) begin m_rd = pre; m_vld = 1'b1; end else m_vld = 1'b0;
      if (m_phase < 0) begin
        if (flush_req) m_phase = 0;
      end else if (m_phase == 8) m_phase = -1;
      else m_phase = m_phase + 1;
    end
    #1;
  endtask

  task automatic fill_all();
    idle_inputs();
    for (int s = 0; s < 8; s++) begin
      for (int w = 0; w < 4; w++) begin
        wr_en = 1'b1; wr_set = 3'(s); wr_way = 2'(w); wr_valid = 1'b1;
        tick();
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs(); reset = 1'b1; tick(); tick(); idle_inputs();
    vectors++;
    if ({rd_valid_ways, rd_vld, flush_busy, flush_done, wr_ready} !== 8'b0000_0001) begin
      miscompares++;
      $display("FAIL reset_state: got %b want 00000001", {rd_valid_ways, rd_vld, flush_busy, flush_done, wr_ready});
    end
    for (int s = 0; s < 8; s++) begin
      rd_en = 1'b1; rd_set = 3'(s); tick();
      vectors++;
      if (rd_valid_ways !== 4'b0000 || rd_vld !== 1'b1 || wr_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL reset_read set %0d: ways=%b vld=%b rdy=%b want 0000/1/1", s, rd_valid_ways, rd_vld, wr_ready);
      end
    end
    idle_inputs(); tick();
    vectors++;
    if (rd_vld !== 1'b0) begin
      miscompares++; $display("FAIL rd_vld_pulse: got %b want 0", rd_vld);
    end
  endtask

  task automatic test_write_read();
    idle_inputs(); wr_en = 1'b1; wr_set = 3'd5; wr_way = 2'd2; wr_valid = 1'b1; tick();
    idle_inputs(); rd_en = 1'b1; rd_set = 3'd5; tick();
    vectors++;
    if (rd_valid_ways !== 4'b0100) begin
      miscompares++; $display("FAIL write_then_read: got %b want 0100", rd_valid_ways);
    end
    wr_en = 1'b1; wr_set = 3'd5; wr_way = 2'd2; wr_valid = 1'b0; rd_en = 1'b1; rd_set = 3'd5; tick();
    vectors++;
    if (rd_valid_ways !== 4'b0100) begin
      miscompares++; $display("FAIL same_edge_read: got %b want 0100", rd_valid_ways);
    end
    idle_inputs(); rd_en = 1'b1; rd_set = 3'd5; tick();
    vectors++;
    if (rd_valid_ways !== 4'b0000) begin
      miscompares++; $display("FAIL invalidate: got %b want 0000", rd_valid_ways);
    end
    idle_inputs();
  endtask

  task automatic test_flush();
    logic [3:0] exp_rd;
    fill_all();
    flush_req = 1'b1; tick();   // edge N
    idle_inputs();
    for (int j = 1; j <= 10; j++) begin
      rd_en = 1'b1; rd_set = (j == 2) ? 3'd0 : 3'd7;
      tick();
      exp_rd = (j == 2 || j >= 9) ? 4'b0000 : 4'b1111;
      vectors++;
      if (flush_busy !== (j <= 7) || flush_done !== (j == 8) || wr_ready !== (j > 7) || rd_valid_ways !== exp_rd) begin
        miscompares++;
        $display("FAIL flush_seq j=%0d: busy=%b done=%b rdy=%b ways=%b want %b/%b/%b/%b",
                 j, flush_busy, flush_done, wr_ready, rd_valid_ways, j <= 7, j == 8, j > 7, exp_rd);
      end
    end
    for (int s = 0; s < 8; s++) begin
      rd_en = 1'b1; rd_set = 3'(s); tick();
      vectors++;
      if (rd_valid_ways !== 4'b0000) begin
        miscompares++; $display("FAIL post_flush set %0d: got %b want 0000", s, rd_valid_ways);
      end
    end
    idle_inputs();
  endtask

  task automatic test_write_during_flush();
    idle_inputs(); flush_req = 1'b1; tick(); idle_inputs();
    for (int j = 1; j <= 11; j++) begin
      if (j <= 8) begin
        vectors++;
        if (wr_ready !== 1'b0) begin
          miscompares++; $display("FAIL ready_in_flush j=%0d: got %b want 0", j, wr_ready);
        end
        wr_en = 1'b1; wr_set = 3'd3; wr_way = 2'd1; wr_valid = 1'b1;
      end else begin
        wr_en = 1'b0;
      end
      flush_req = (j == 4);
      tick();
      vectors++;
      if (flush_busy !== (j <= 7) || flush_done !== (j == 8)) begin
        miscompares++;
        $display("FAIL no_reflush j=%0d: busy=%b done=%b want %b/%b", j, flush_busy, flush_done, j <= 7, j == 8);
      end
    end
    idle_inputs(); rd_en = 1'b1; rd_set = 3'd3; tick();
    vectors++;
    if (rd_valid_ways !== 4'b0000) begin
      miscompares++; $display("FAIL dropped_write: got %b want 0000", rd_valid_ways);
    end
    idle_inputs();
  endtask

  task automatic test_write_flush_same_edge();
    idle_inputs();
    wr_en = 1'b1; wr_set = 3'd7; wr_way = 2'd3; wr_valid = 1'b1; flush_req = 1'b1;
    tick(); idle_inputs();
    for (int j = 1; j <= 9; j++) begin
      rd_en = 1'b1; rd_set = 3'd7; tick();
      vectors++;
      if (rd_valid_ways !== ((j <= 8) ? 4'b1000 : 4'b0000)) begin
        miscompares++;
        $display("FAIL wr_flush_same j=%0d: got %b want %b", j, rd_valid_ways, (j <= 8) ? 4'b1000 : 4'b0000);
      end
    end
    idle_inputs(); tick();
  endtask

  task automatic test_reset_mid_flush();
    fill_all();
    flush_req = 1'b1; tick(); idle_inputs();
    tick(); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    vectors++;
    if ({rd_valid_ways, rd_vld, flush_busy, flush_done, wr_ready} !== 8'b0000_0001) begin
      miscompares++;
      $display("FAIL reset_mid_flush: got %b want 00000001", {rd_valid_ways, rd_vld, flush_busy, flush_done, wr_ready});
    end
    for (int s = 0; s < 8; s++) begin
      rd_en = 1'b1; rd_set = 3'(7 - s); tick();
      vectors++;
      if (rd_valid_ways !== 4'b0000 || flush_busy !== 1'b0 || flush_done !== 1'b0) begin
        miscompares++;
        $display("FAIL after_abort set %0d: ways=%b busy=%b done=%b want 0000/0/0", 7 - s, rd_valid_ways, flush_busy, flush_done);
      end
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    idle_inputs(); flush_req = 1'b1; tick();
    for (int j = 1; j <= 11; j++) begin
      tick();
      vectors++;
      if (flush_busy !== (j <= 7 || j >= 10) || flush_done !== (j == 8)) begin
        miscompares++;
        $display("FAIL back_to_back j=%0d: busy=%b done=%b want %b/%b", j, flush_busy, flush_done, j <= 7 || j >= 10, j == 8);
      end
    end
    idle_inputs();
    for (int j = 0; j < 9; j++) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      wr_en     = $urandom_range(0, 1);
      wr_set    = 3'($urandom_range(0, 7));
      wr_way    = 2'($urandom_range(0, 3));
      wr_valid  = ($urandom_range(0, 3) != 0);
      flush_req = ($urandom_range(0, 39) == 0);
      rd_en     = $urandom_range(0, 1);
      rd_set    = 3'($urandom_range(0, 7));
      tick();
      vectors++;
      if (rd_valid_ways !== m_rd || rd_vld !== m_vld || flush_busy !== (m_phase >= 0 && m_phase < 8) ||
          flush_done !== (m_phase == 8) || wr_ready !== !(m_phase >= 0 && m_phase < 8)) begin
        miscompares++;
        $display("FAIL random i=%0d: ways=%b vld=%b busy=%b done=%b rdy=%b want ways=%b vld=%b phase=%0d",
                 i, rd_valid_ways, rd_vld, flush_busy, flush_done, wr_ready, m_rd, m_vld, m_phase);
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_write_read();
    test_flush();
    test_write_during_flush();
    test_write_flush_same_edge();
    test_reset_mid_flush();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
